dmem_io: RTL
============

DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits of the RAM (depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter KB_DEPTH, default 8, meaning keyboard FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port cs  in  1  meaning access select.
REQ-006 SHALL have port rd  in  1  meaning read request, qualified by cs.
REQ-007 SHALL have port wr  in  1  meaning write request, qualified by cs.
REQ-008 SHALL have port be  in  4  meaning byte-lane write enables; be[0] selects wdata[7:0].
REQ-009 SHALL have port addr  in  32  meaning byte address.
REQ-010 SHALL have port wdata  in  32  meaning write data.
REQ-011 SHALL have port rdata  out  32  meaning registered read data.
REQ-012 SHALL have port rvalid  out  1  meaning one-cycle pulse marking rdata valid.
REQ-013 SHALL have port kb_valid  in  1  meaning one-cycle strobe for a new scancode.
REQ-014 SHALL have port kb_data  in  8  meaning scancode, sampled when kb_valid=1.
REQ-015 SHALL have port irq  out  1  meaning keyboard FIFO non-empty.

Function
REQ-016 SHALL decode addr[15:12]: 0x0 -> RAM word addr[ADDR_W+1:2]; 0x1 -> keyboard registers; other values -> unmapped.
REQ-017 SHALL write RAM on a rising edge with cs=1, wr=1: only lanes with be[i]=1 are updated; be=0000 changes nothing.
REQ-018 SHALL, on cs=1, rd=1, wr=0, drive rdata and pulse rvalid=1 on the next cycle (latency 1); rvalid SHALL be 0 otherwise.
REQ-019 SHALL give wr priority when cs=1, rd=1, wr=1: the write is performed, the read is ignored, and no rvalid is produced.
REQ-020 SHALL hold rdata at its last value while rvalid=0.
REQ-021 SHALL make keyboard register 0x1000 (KB_DATA) read as {24'b0, head byte} and pop one entry; when the FIFO is empty the read SHALL return 0x00000000 and not pop.
REQ-022 SHALL make keyboard register 0x1004 (KB_STAT) read as {30'b0, ovf, nonempty}.
REQ-023 SHALL clear ovf on a write to 0x1004 with wdata[1]=1 and be[0]=1; all other keyboard-region writes are ignored.
REQ-024 SHALL make unmapped reads return 0x00000000 with rvalid and make unmapped writes have no effect.
REQ-025 SHALL push kb_data when kb_valid=1 and the FIFO is not full; when the FIFO is full the byte SHALL be dropped and ovf set (sticky).
REQ-026 SHALL, on a simultaneous push and pop with the FIFO full, perform both, keeping the count unchanged and leaving ovf unset.
REQ-027 SHALL, on a simultaneous push and pop with the FIFO empty, return 0 for the read and store the pushed byte.
REQ-028 SHALL wrap read and write pointers modulo KB_DEPTH and keep the count in the range 0..KB_DEPTH.
REQ-029 SHALL drive irq=nonempty as a registered signal, so it rises one cycle after the first push.
REQ-030 SHALL not return data a byte-lane write made in the same cycle to a read of that cycle, since a read in a write cycle is ignored (REQ-019).

Reset
REQ-031 SHALL, with rst_n=0, clear rdata, rvalid, irq, ovf, the FIFO pointers and the count to 0 immediately.
REQ-032 SHALL not reset RAM contents.
REQ-033 SHALL discard a read issued in the cycle reset asserts: no rvalid after release.
REQ-034 SHALL ignore kb_valid while rst_n=0.

Configuration
REQ-035 SHALL, with macro DMEM_KB_FIFO_EN defined, implement the keyboard buffer as a KB_DEPTH-entry FIFO.
REQ-036 SHALL, without DMEM_KB_FIFO_EN, implement a single holding register (effective depth 1), ignore KB_DEPTH, and keep the same register map, ovf and irq rules.

Verification
REQ-037 SHALL test: write 0x11223344 to 0x0010 with be=1111, then be=0100 wdata=0xAABBCCDD, then read 0x0010 -> rdata=0x11BB3344 with rvalid one cycle after rd.
REQ-038 SHALL test: push 0x1C, 0x32, 0x21, then read 0x1000 three times -> 0x1C, 0x32, 0x21 in order, a fourth read -> 0, and KB_STAT=0.
REQ-039 SHALL test: push KB_DEPTH+1 bytes (0x01..0x09) -> KB_STAT=0x3, the first 8 reads return 0x01..0x08; after a write of 0x2 to 0x1004, KB_STAT=0x1 before those reads.
REQ-040 SHALL test: with the FIFO full, kb_valid=0x5A in the same cycle as a KB_DATA read -> oldest byte returned, ovf=0, and 0x5A read last.
REQ-041 SHALL test: cs=1, rd=1, wr=1 at 0x0020 -> write performed and no rvalid; a read of 0x3000 -> 0 with rvalid.
REQ-042 SHALL test: assert rst_n=0 with 3 entries buffered and a read in flight -> rvalid=0, irq=0, KB_STAT=0, and RAM data kept.

Source files
------------

// File: rtl/dmem_io.sv
// Data memory with a memory-mapped keyboard port.
// 0x0xxx selects the word RAM, 0x1000 is KB_DATA (pop), 0x1004 is KB_STAT.
// Any other value of addr[15:12] is unmapped.
// Define DMEM_KB_FIFO_EN to get a KB_DEPTH-entry keyboard FIFO.
// Without it, the keyboard uses one holding register and KB_DEPTH is ignored.
module dmem_io #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned KB_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        irq
);

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic              acc_rd, acc_wr;
  logic              sel_ram, sel_kb, sel_kb_data, sel_kb_stat;
  logic [ADDR_W-1:0] ram_idx;

  // A write wins over a simultaneous read; the read is simply dropped.
  assign acc_wr      = cs & wr;
  assign acc_rd      = cs & rd & ~wr;
  assign sel_ram     = (addr[15:12] == 4'h0);
  assign sel_kb      = (addr[15:12] == 4'h1);
  assign sel_kb_data = sel_kb & (addr[11:2] == 10'd0);
  assign sel_kb_stat = sel_kb & (addr[11:2] == 10'd1);
  assign ram_idx     = addr[ADDR_W+1:2];

  logic unused_addr;
  assign unused_addr = ^{addr[31:16], addr[1:0]};

  // ---------------------------------------------------------------------------
  // Word RAM (contents survive reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [2**ADDR_W];

  // Byte-lane write into the RAM
  always_ff @(posedge clk) begin
    if (acc_wr && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard buffer control shared by both storage variants
  // ---------------------------------------------------------------------------
  logic       kb_full, kb_nonempty, kb_nonempty_d;
  logic [7:0] kb_head;
  logic       kb_pop, kb_push, kb_drop, ovf_clr;

  // A pop frees a slot in the same cycle, so a push into a full buffer still lands.
  assign kb_pop  = acc_rd & sel_kb_data & kb_nonempty;
  assign kb_push = kb_valid & (~kb_full | kb_pop);
  assign kb_drop = kb_valid & kb_full & ~kb_pop;
  assign ovf_clr = acc_wr & sel_kb_stat & be[0] & wdata[1];

`ifdef DMEM_KB_FIFO_EN
  localparam int unsigned PtrW = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;

  logic [7:0]      fifo_mem [KB_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;

  assign kb_full       = (cnt_q == (PtrW+1)'(KB_DEPTH));
  assign kb_nonempty   = (cnt_q != '0);
  assign kb_nonempty_d = (cnt_d != '0);
  assign kb_head       = fifo_mem[rptr_q];

  // Pointer and occupancy next state; power-of-two depth lets pointers wrap freely
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (kb_push) wptr_d = wptr_q + PtrW'(1);
    if (kb_pop)  rptr_d = rptr_q + PtrW'(1);
    unique case ({kb_push, kb_pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO storage, no reset needed since the count gates every read
  always_ff @(posedge clk) begin
    if (kb_push) fifo_mem[wptr_q] <= kb_data;
  end
`else
  logic       hold_full_q, hold_full_d;
  logic [7:0] hold_q, hold_d;
  logic       unused_kb_depth;

  assign unused_kb_depth = ^KB_DEPTH;
  assign kb_full         = hold_full_q;
  assign kb_nonempty     = hold_full_q;
  assign kb_nonempty_d   = hold_full_d;
  assign kb_head         = hold_q;

  // Single-entry buffer: a push overrides a pop, so push+pop replaces the byte
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (kb_push) begin
      hold_full_d = 1'b1;
      hold_d      = kb_data;
    end else if (kb_pop) begin
      hold_full_d = 1'b0;
    end
  end

  // Holding register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q <= 1'b0;
      hold_q      <= 8'h00;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Overflow flag, interrupt and read port
  // ---------------------------------------------------------------------------
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rd_word;

  // Read data mux for the addressed location
  always_comb begin
    rd_word = 32'h0;
    if (sel_ram) begin
      rd_word = mem[ram_idx];
    end else if (sel_kb_data) begin
      rd_word = kb_nonempty ? {24'h0, kb_head} : 32'h0;
    end else if (sel_kb_stat) begin
      rd_word = {30'h0, ovf_q, kb_nonempty};
    end
  end

  // Next state for status and read port; a dropped byte beats a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (kb_drop)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    irq_d    = kb_nonempty_d;
    rvalid_d = acc_rd;
    rdata_d  = acc_rd ? rd_word : rdata_q;
  end

  // Status and read-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule
